// File: rtl/ins_cache_param.sv
// ins_cache_param
//   Direct-mapped, read-only instruction cache that sits between the fetch-stage
//   PC and main memory. The line count and words per line are configurable. A
//   three-state FSM handles lookup, line fill and whole-cache flush, and two
//   saturating counters record hits and misses.
//
// Ports
//   clock               system clock, all state changes on posedge
//   reset               synchronous, active-low
//   read                fetch request (address held stable while busywait=1)
//   flush               one-cycle pulse, invalidates every line
//   address             byte PC: [OFF_W+1:2] word offset, next IDX_W bits index, rest tag
//   readdata            selected instruction word, valid when read=1 and busywait=0
//   busywait            stall request to the fetch stage
//   hit_count           saturating hit counter
//   miss_count          saturating miss counter
//   MAIN_MEM_READ       line fetch request
//   MAIN_MEM_ADDRESS    block address {tag,index} of the line being fetched
//   MAIN_MEM_READ_DATA  returned line, word 0 in bits [31:0]
//   MAIN_MEM_BUSY_WAIT  memory busy; data valid in the cycle it drops
module ins_cache_param #(
   parameter int  NUM_LINES      = 8,
   parameter int  WORDS_PER_LINE = 4,
   parameter int  CNT_W          = 32,
   localparam int IDX_W          = $clog2(NUM_LINES),
   localparam int OFF_W          = $clog2(WORDS_PER_LINE),
   localparam int LINE_W         = 32 * WORDS_PER_LINE,
   localparam int BLK_W          = 30 - OFF_W,
   localparam int TAG_W          = BLK_W - IDX_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              read,
   input  logic              flush,
   input  logic [31:0]       address,
   output logic [31:0]       readdata,
   output logic              busywait,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count,
   output logic              MAIN_MEM_READ,
   output logic [BLK_W-1:0]  MAIN_MEM_ADDRESS,
   input  logic [LINE_W-1:0] MAIN_MEM_READ_DATA,
   input  logic              MAIN_MEM_BUSY_WAIT
);

   typedef enum logic [1:0] {IDLE, MEM_READ, FLUSH} state_t;

   state_t             state;
   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem  [NUM_LINES];
   logic [LINE_W-1:0]  data_mem [NUM_LINES];
   logic [BLK_W-1:0]   blk_reg;
   logic [IDX_W-1:0]   flush_ctr;
   logic               flush_pend;
   logic [31:0]        last_word;

   logic [OFF_W-1:0]   off;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   fill_idx;
   logic [31:0]        cur_word;
   logic               tag_ok;
   logic               hit;
   logic               fill_done;
   logic               addr_unused;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign off       = address[2 +: OFF_W];
   assign idx       = address[2 + OFF_W +: IDX_W];
   assign fill_idx  = blk_reg[IDX_W-1:0];
   assign cur_word  = data_mem[idx][{off, 5'b0} +: 32];
   assign tag_ok    = valid[idx] && (tag_mem[idx] == address[31 -: TAG_W]);
   // A flush in the same cycle takes priority, so the read is not served.
   assign hit       = reset && (state == IDLE) && read && !flush && tag_ok;
   assign fill_done = (state == MEM_READ) && !MAIN_MEM_BUSY_WAIT;
   assign addr_unused = &{1'b0, address[1:0]};

   // Memory-side outputs depend only on registered state (and reset gating).
   assign MAIN_MEM_READ    = reset && (state == MEM_READ);
   assign MAIN_MEM_ADDRESS = blk_reg;

   // Hit data is forwarded combinationally; otherwise the last hit word is held.
   assign readdata = !reset ? 32'h0 : (hit ? cur_word : last_word);

   always_comb begin
      busywait = 1'b0;
      if (reset) begin
         case (state)
            IDLE:    busywait = flush || (read && !tag_ok);
            default: busywait = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         valid      <= '0;
         hit_count  <= '0;
         miss_count <= '0;
         flush_pend <= 1'b0;
         flush_ctr  <= '0;
         blk_reg    <= '0;
         last_word  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  state     <= FLUSH;
                  flush_ctr <= '0;
               end else if (read) begin
                  if (tag_ok) begin
                     hit_count <= sat_inc(hit_count);
                     last_word <= cur_word;
                  end else begin
                     miss_count <= sat_inc(miss_count);
                     blk_reg    <= address[31 -: BLK_W];
                     state      <= MEM_READ;
                  end
               end
            end
            MEM_READ: begin
               // A flush arriving mid-fill is remembered and run once the line lands.
               if (flush) flush_pend <= 1'b1;
               if (!MAIN_MEM_BUSY_WAIT) begin
                  valid[fill_idx] <= 1'b1;
                  flush_pend      <= 1'b0;
                  flush_ctr       <= '0;
                  state           <= (flush_pend || flush) ? FLUSH : IDLE;
               end
            end
            FLUSH: begin
               valid[flush_ctr] <= 1'b0;
               flush_ctr        <= flush_ctr + IDX_W'(1);
               if (flush_ctr == IDX_W'(NUM_LINES - 1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line storage carries no reset; the valid bits alone decide whether it is used.
   always_ff @(posedge clock) begin
      if (reset && fill_done) begin
         data_mem[fill_idx] <= MAIN_MEM_READ_DATA;
         tag_mem[fill_idx]  <= blk_reg[BLK_W-1 -: TAG_W];
      end
   end

endmodule

// File: tb/tb_ins_cache_param.sv
module tb_ins_cache_param;
   localparam int NL  = 8;
   localparam int WPL = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, rd, fl;
   logic [31:0]  addr, rdata;
   logic         bw;
   logic [31:0]  hc, mc;
   logic         mrd, mbusy;
   logic [27:0]  maddr;
   logic [127:0] mline;

   logic         rd2;
   logic [31:0]  addr2, rdata2;
   logic         bw2;
   logic [1:0]   hc2, mc2;
   logic         mrd2;
   logic [26:0]  maddr2;
   logic [255:0] mline2;

   int lat = 1;
   int mcnt = 0;
   int rd_cycles = 0;
   int tests = 0;
   int fails = 0;
   logic [27:0] last_maddr  = '0;
   logic [26:0] last_maddr2 = '0;

   // Reference model: which block each line holds, plus expected counters.
   bit          ref_v   [NL];
   int unsigned ref_blk [NL];
   int unsigned ref_hits = 0;
   int unsigned ref_misses = 0;

   typedef struct {
      logic [31:0] a;
      int          lat;
      int          busy;
      int          hits;
      int          misses;
   } vec_t;
   vec_t vecs [7];

   function automatic logic [31:0] mem_word(input logic [31:0] blk, input logic [31:0] w);
      return (blk * 32'h9E37_79B9) ^ (w * 32'h0101_0101) ^ 32'h5A5A_0000;
   endfunction

   always_comb begin
      mline = '0;
      for (int w = 0; w < WPL; w++) mline[32*w +: 32] = mem_word({4'b0, maddr}, w);
      mline2 = '0;
      for (int w = 0; w < 8; w++) mline2[32*w +: 32] = mem_word({5'b0, maddr2}, w);
   end

   // Main memory with a programmable number of cycles per line fetch.
   assign mbusy = mrd && (mcnt < lat - 1);
   always_ff @(posedge clk) mcnt <= (mrd && mbusy) ? mcnt + 1 : 0;

   always @(negedge clk) begin
      if (mrd) begin
         rd_cycles  = rd_cycles + 1;
         last_maddr = maddr;
      end
      if (mrd2) last_maddr2 = maddr2;
   end

   ins_cache_param dut (
      .clock(clk), .reset(rst_n), .read(rd), .flush(fl), .address(addr),
      .readdata(rdata), .busywait(bw), .hit_count(hc), .miss_count(mc),
      .MAIN_MEM_READ(mrd), .MAIN_MEM_ADDRESS(maddr),
      .MAIN_MEM_READ_DATA(mline), .MAIN_MEM_BUSY_WAIT(mbusy)
   );

   ins_cache_param #(.NUM_LINES(16), .WORDS_PER_LINE(8), .CNT_W(2)) dut2 (
      .clock(clk), .reset(rst_n), .read(rd2), .flush(1'b0), .address(addr2),
      .readdata(rdata2), .busywait(bw2), .hit_count(hc2), .miss_count(mc2),
      .MAIN_MEM_READ(mrd2), .MAIN_MEM_ADDRESS(maddr2),
      .MAIN_MEM_READ_DATA(mline2), .MAIN_MEM_BUSY_WAIT(1'b0)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear_valid();
      for (int i = 0; i < NL; i++) ref_v[i] = 1'b0;
   endtask

   // Issue one fetch (optionally together with a flush) and check it end to end.
   // Entered and left at posedge+1.
   task automatic fetch(input logic [31:0] a, input bit with_flush, output int busy);
      int unsigned blk;
      int          ix;
      int          rc0;
      bit          exp_hit;
      blk = a >> 4;
      ix  = int'(blk % NL);
      if (with_flush) model_clear_valid();
      exp_hit = ref_v[ix] && (ref_blk[ix] == blk);
      rc0  = rd_cycles;
      busy = 0;
      rd   = 1'b1;
      addr = a;
      fl   = with_flush;
      @(negedge clk);
      while (bw && busy < 300) begin
         busy++;
         @(posedge clk);
         #1 fl = 1'b0;
         @(negedge clk);
      end
      check("fetch_busy", busy, exp_hit ? 0 : (with_flush ? NL + 2 + lat : 1 + lat));
      check("fetch_data", rdata, mem_word(blk, (a >> 2) % WPL));
      check("fetch_memrd_cycles", rd_cycles - rc0, exp_hit ? 0 : lat);
      if (!exp_hit) check("fetch_mem_addr", last_maddr, blk);
      if (!exp_hit) begin
         ref_misses++;
         ref_v[ix]   = 1'b1;
         ref_blk[ix] = blk;
      end
      ref_hits++;
      @(posedge clk);
      #1 rd = 1'b0;
      fl = 1'b0;
      check("fetch_hit_count", hc, ref_hits);
      check("fetch_miss_count", mc, ref_misses);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int busy;
      vecs[0] = '{32'h0000_0004, 3, 4, 1, 1};
      vecs[1] = '{32'h0000_0000, 1, 0, 2, 1};
      vecs[2] = '{32'h0000_0008, 1, 0, 3, 1};
      vecs[3] = '{32'h0000_000C, 1, 0, 4, 1};
      vecs[4] = '{32'h0000_0000, 1, 0, 5, 1};
      vecs[5] = '{32'h0000_0080, 1, 2, 6, 2};
      vecs[6] = '{32'h0000_0000, 2, 3, 7, 3};
      model_clear_valid();

      rst_n = 1'b0; rd = 1'b0; fl = 1'b0; addr = '0; rd2 = 1'b0; addr2 = '0;
      @(negedge clk);
      check("rst_busywait", bw, 0);
      check("rst_memread", mrd, 0);
      check("rst_readdata", rdata, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_hit_count", hc, 0);
      check("rst_miss_count", mc, 0);
      check("rst_idle_busywait", bw, 0);
      @(posedge clk);
      #1;

      // Wide-line instance: 16 lines x 8 words, 2-bit saturating counters.
      rd2 = 1'b1; addr2 = 32'h0000_011C; busy = 0;
      @(negedge clk);
      while (bw2 && busy < 50) begin busy++; @(negedge clk); end
      check("p2_busy", busy, 2);
      check("p2_mem_addr", last_maddr2, 27'h8);
      check("p2_data", rdata2, mem_word(32'h8, 32'd7));
      repeat (5) @(posedge clk);
      #1 rd2 = 1'b0;
      check("p2_hit_saturate", hc2, 2'd3);
      check("p2_miss_count", mc2, 2'd1);

      // Directed cold miss, sequential hits and index conflict.
      for (int i = 0; i < 7; i++) begin
         lat = vecs[i].lat;
         fetch(vecs[i].a, 1'b0, busy);
         check("tbl_busy", busy, vecs[i].busy);
         check("tbl_hits", hc, vecs[i].hits);
         check("tbl_misses", mc, vecs[i].misses);
      end

      // Flush pulsed while a fill is in progress.
      lat = 3;
      rd = 1'b1; addr = 32'h0000_0200;
      @(negedge clk);
      check("ff_miss_busy", bw, 1);
      @(posedge clk);
      #1 fl = 1'b1; rd = 1'b0;
      @(negedge clk);
      check("ff_memread", mrd, 1);
      @(posedge clk);
      #1 fl = 1'b0;
      busy = 1;
      @(negedge clk);
      while (bw && busy < 300) begin busy++; @(negedge clk); end
      check("ff_tail_busy", busy, 3 + NL);
      ref_misses++;
      model_clear_valid();
      @(posedge clk);
      #1;
      check("ff_hit_count", hc, ref_hits);
      check("ff_miss_count", mc, ref_misses);
      fetch(32'h0000_0200, 1'b0, busy);
      check("ff_refetch_missed", busy, 1 + lat);
      fetch(32'h0000_0204, 1'b0, busy);

      // Reset asserted in the middle of a fill.
      rd = 1'b1; addr = 32'h0000_0300;
      @(negedge clk);
      check("rm_miss_busy", bw, 1);
      @(posedge clk);
      #1 rst_n = 1'b0; rd = 1'b0;
      @(negedge clk);
      check("rm_memread", mrd, 0);
      check("rm_busywait", bw, 0);
      check("rm_readdata", rdata, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rm_hit_count", hc, 0);
      check("rm_miss_count", mc, 0);
      check("rm_memread_held", mrd, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_clear_valid();
      ref_hits = 0;
      ref_misses = 0;
      lat = 2;
      fetch(32'h0000_0300, 1'b0, busy);
      check("rm_line_invalid", busy, 1 + lat);
      fetch(32'h0000_0000, 1'b0, busy);

      // Random fetches over a small footprint, occasionally combined with a flush.
      for (int n = 0; n < 120; n++) begin
         lat = int'($urandom_range(1, 4));
         fetch({22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
               ($urandom_range(0, 15) == 0), busy);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
